// File: rtl/wasm_host_loader.sv
// Host-side sequencer: packs host bytes into 64-bit instruction words,
// writes them to instruction memory, runs the core until it reports done,
// then streams a window of line memory back to the host.
module wasm_host_loader #(
  parameter int unsigned RD_LAT     = 2,
  parameter int unsigned TIMEOUT    = 1000000,
  parameter logic [1:0]  DONE_STATE = 2'b11
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [14:0] i_word_cnt,
  input  logic [8:0]  i_rd_base,
  input  logic [9:0]  i_rd_cnt,
  input  logic        i_byte_vld,
  output logic        o_byte_rdy,
  input  logic [7:0]  i_byte_data,
  output logic        o_res_vld,
  input  logic        i_res_rdy,
  output logic [31:0] o_res_data,
  output logic [8:0]  o_res_addr,
  output logic        o_instr_mem_wr_vld,
  output logic [14:0] o_instr_mem_wr_addr,
  output logic [63:0] o_instr_mem_wr_data,
  input  logic        i_instr_mem_wr_rdy,
  output logic        o_instr_mem_wr_finish,
  input  logic [1:0]  i_work_state,
  input  logic [2:0]  i_error,
  output logic        o_line_mem_rd_rdy,
  output logic [8:0]  o_line_mem_rd_addr,
  input  logic [31:0] i_line_mem_rd_data,
  output logic        o_busy,
  output logic        o_done,
  output logic [1:0]  o_fault,
  output logic [31:0] o_cycles
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FINISH,
    S_RUN,
    S_DUMP,
    S_FAULT
  } state_t;

  localparam logic [7:0] LAT_INIT = 8'(RD_LAT);

  state_t      state;
  state_t      next;
  logic        error_hit;
  logic        timeout_hit;
  logic        byte_rdy;

  logic [63:0] pack;
  logic [2:0]  byte_idx;
  logic        wr_pending;
  logic [14:0] word_idx;
  logic [14:0] word_cnt;
  logic        finish;
  logic [31:0] cycles;
  logic [8:0]  rd_addr;
  logic [9:0]  rd_left;
  logic [7:0]  lat;
  logic        res_vld;
  logic [31:0] res_data;
  logic [8:0]  res_addr;
  logic        done;
  logic [1:0]  fault;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= next;
  end

  // Next-state selection; a fault overrides every other transition
  always_comb begin
    next        = state;
    byte_rdy    = 1'b0;
    error_hit   = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      S_IDLE:   if (i_start) next = (i_word_cnt == '0) ? S_FINISH : S_LOAD;
      S_LOAD: begin
        byte_rdy = !wr_pending;
        if (wr_pending && i_instr_mem_wr_rdy && word_idx == word_cnt - 15'd1)
          next = S_FINISH;
      end
      S_FINISH: next = S_RUN;
      S_RUN:    if (i_work_state == DONE_STATE) next = S_DUMP;
      S_DUMP: begin
        if (rd_left == '0) next = S_IDLE;
        else if (res_vld && i_res_rdy && rd_left == 10'd1) next = S_IDLE;
      end
      S_FAULT:  next = S_IDLE;
      default:  next = S_IDLE;
    endcase
    error_hit   = (state != S_IDLE) && (state != S_FAULT) && (i_error != '0);
    timeout_hit = (state == S_RUN) && (TIMEOUT != 0) && (cycles == TIMEOUT);
    if (error_hit || timeout_hit) next = S_FAULT;
  end

  // Datapath: byte packing, write handshake, run counter, dump sequencing
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pack       <= '0;
      byte_idx   <= '0;
      wr_pending <= 1'b0;
      word_idx   <= '0;
      word_cnt   <= '0;
      finish     <= 1'b0;
      cycles     <= '0;
      rd_addr    <= '0;
      rd_left    <= '0;
      lat        <= '0;
      res_vld    <= 1'b0;
      res_data   <= '0;
      res_addr   <= '0;
      done       <= 1'b0;
      fault      <= '0;
    end else begin
      done   <= (state == S_DUMP) && (next == S_IDLE);
      finish <= (next == S_FINISH) || (finish && next != S_IDLE);
      case (state)
        S_IDLE: begin
          if (i_start) begin
            word_cnt   <= i_word_cnt;
            word_idx   <= '0;
            byte_idx   <= '0;
            wr_pending <= 1'b0;
            rd_addr    <= i_rd_base;
            rd_left    <= i_rd_cnt;
            fault      <= '0;
          end
        end
        S_LOAD: begin
          if (!wr_pending && i_byte_vld) begin
            pack[{byte_idx, 3'b000} +: 8] <= i_byte_data;
            byte_idx <= byte_idx + 3'd1;
            if (byte_idx == 3'd7) wr_pending <= 1'b1;
          end else if (wr_pending && i_instr_mem_wr_rdy) begin
            wr_pending <= 1'b0;
            word_idx   <= word_idx + 15'd1;
          end
        end
        S_FINISH: cycles <= '0;
        S_RUN: begin
          if (next == S_RUN && cycles != '1) cycles <= cycles + 32'd1;
          if (next == S_DUMP) lat <= LAT_INIT;
        end
        S_DUMP: begin
          if (rd_left != '0) begin
            if (!res_vld) begin
              if (lat == '0) begin
                res_vld  <= 1'b1;
                res_data <= i_line_mem_rd_data;
                res_addr <= rd_addr;
              end else begin
                lat <= lat - 8'd1;
              end
            end else if (i_res_rdy) begin
              res_vld <= 1'b0;
              rd_left <= rd_left - 10'd1;
              rd_addr <= rd_addr + 9'd1;
              lat     <= LAT_INIT;
            end
          end
        end
        default: ;
      endcase
      // Abort drops any in-flight write or result presented to the host
      if (next == S_FAULT && state != S_FAULT) begin
        fault      <= error_hit ? 2'b01 : 2'b10;
        wr_pending <= 1'b0;
        res_vld    <= 1'b0;
      end
    end
  end

  assign o_byte_rdy            = byte_rdy;
  assign o_instr_mem_wr_vld    = wr_pending;
  assign o_instr_mem_wr_addr   = word_idx;
  assign o_instr_mem_wr_data   = pack;
  assign o_instr_mem_wr_finish = finish;
  assign o_line_mem_rd_rdy     = (state == S_DUMP);
  assign o_line_mem_rd_addr    = rd_addr;
  assign o_res_vld             = res_vld;
  assign o_res_data            = res_data;
  assign o_res_addr            = res_addr;
  assign o_busy                = (state != S_IDLE);
  assign o_done                = done;
  assign o_fault               = fault;
  assign o_cycles              = cycles;

endmodule

// File: tb/tb_wasm_host_loader.sv
// Directed bench for wasm_host_loader: load, backpressure, run/dump,
// address wrap, error and timeout faults, reset mid-load.
module tb_wasm_host_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [14:0] word_cnt;
  logic [8:0]  rd_base;
  logic [9:0]  rd_cnt;
  logic        byte_vld;
  logic        byte_rdy;
  logic [7:0]  byte_data;
  logic        res_vld;
  logic        res_rdy;
  logic [31:0] res_data;
  logic [8:0]  res_addr;
  logic        wr_vld;
  logic [14:0] wr_addr;
  logic [63:0] wr_data;
  logic        wr_rdy;
  logic        wr_finish;
  logic [1:0]  work_state;
  logic [2:0]  err;
  logic        rd_rdy;
  logic [8:0]  rd_addr;
  logic [31:0] rd_data;
  logic        busy;
  logic        done;
  logic [1:0]  fault;
  logic [31:0] cycles;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  wasm_host_loader #(
    .RD_LAT     (2),
    .TIMEOUT    (50),
    .DONE_STATE (2'b11)
  ) dut (
    .i_clk                 (clk),
    .i_rst                 (rst),
    .i_start               (start),
    .i_word_cnt            (word_cnt),
    .i_rd_base             (rd_base),
    .i_rd_cnt              (rd_cnt),
    .i_byte_vld            (byte_vld),
    .o_byte_rdy            (byte_rdy),
    .i_byte_data           (byte_data),
    .o_res_vld             (res_vld),
    .i_res_rdy             (res_rdy),
    .o_res_data            (res_data),
    .o_res_addr            (res_addr),
    .o_instr_mem_wr_vld    (wr_vld),
    .o_instr_mem_wr_addr   (wr_addr),
    .o_instr_mem_wr_data   (wr_data),
    .i_instr_mem_wr_rdy    (wr_rdy),
    .o_instr_mem_wr_finish (wr_finish),
    .i_work_state          (work_state),
    .i_error               (err),
    .o_line_mem_rd_rdy     (rd_rdy),
    .o_line_mem_rd_addr    (rd_addr),
    .i_line_mem_rd_data    (rd_data),
    .o_busy                (busy),
    .o_done                (done),
    .o_fault               (fault),
    .o_cycles              (cycles)
  );

  // Line memory model: data follows the address two clocks later
  logic [8:0] a1 = '0;
  logic [8:0] a2 = '0;
  always @(posedge clk) begin
    a1 <= rd_addr;
    a2 <= a1;
  end
  assign rd_data = 32'hC0DE0000 | {23'b0, a2};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int unsigned n;
    n = 0;
    byte_vld  = 1'b1;
    byte_data = b;
    while (!byte_rdy && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) chk("byte_rdy_timeout", 64'(byte_rdy), 64'd1);
    tick();
    byte_vld = 1'b0;
  endtask

  task automatic wait_res();
    int unsigned n;
    n = 0;
    while (!res_vld && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("res_vld_timeout", 64'(res_vld), 64'd1);
  endtask

  task automatic pulse_start(input logic [14:0] wc, input logic [8:0] base, input logic [9:0] cnt);
    word_cnt = wc;
    rd_base  = base;
    rd_cnt   = cnt;
    start    = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=hang expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned n;
    rst = 1'b1; start = 1'b0; word_cnt = '0; rd_base = '0; rd_cnt = '0;
    byte_vld = 1'b0; byte_data = '0; res_rdy = 1'b0; wr_rdy = 1'b0;
    work_state = 2'b00; err = '0;
    tick(); tick(); tick();
    rst = 1'b0;
    tick();

    chk("rst_busy",   64'(busy),      64'd0);
    chk("rst_wrvld",  64'(wr_vld),    64'd0);
    chk("rst_finish", 64'(wr_finish), 64'd0);
    chk("rst_fault",  64'(fault),     64'd0);
    chk("rst_cycles", 64'(cycles),    64'd0);
    chk("rst_rdrdy",  64'(rd_rdy),    64'd0);

    // Load two words with a stalled first write
    pulse_start(15'd2, 9'h100, 10'd3);
    chk("load_busy",    64'(busy),     64'd1);
    chk("load_byterdy", 64'(byte_rdy), 64'd1);
    for (int i = 0; i < 8; i++) send_byte(8'(i));
    for (int i = 0; i < 5; i++) begin
      chk("stall_vld",     64'(wr_vld),   64'd1);
      chk("stall_addr",    64'(wr_addr),  64'd0);
      chk("stall_data",    wr_data,       64'h0706050403020100);
      chk("stall_byterdy", 64'(byte_rdy), 64'd0);
      tick();
    end
    wr_rdy = 1'b1;
    tick();
    chk("w0_accepted", 64'(wr_vld),   64'd0);
    chk("w0_byterdy",  64'(byte_rdy), 64'd1);
    for (int i = 8; i < 16; i++) send_byte(8'(i));
    chk("w1_vld",  64'(wr_vld),  64'd1);
    chk("w1_addr", 64'(wr_addr), 64'd1);
    chk("w1_data", wr_data,      64'h0F0E0D0C0B0A0908);
    tick();
    chk("finish_set", 64'(wr_finish), 64'd1);
    chk("finish_vld", 64'(wr_vld),    64'd0);
    tick();
    chk("run_cyc0", 64'(cycles), 64'd0);
    for (int i = 0; i < 40; i++) tick();
    chk("run_cyc40", 64'(cycles), 64'd40);
    work_state = 2'b11;
    tick();
    work_state = 2'b00;
    chk("dump_cycles", 64'(cycles), 64'd40);
    chk("dump_rdrdy",  64'(rd_rdy), 64'd1);
    res_rdy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_res();
      chk("dump_addr", 64'(res_addr), 64'(9'h100 + 9'(k)));
      chk("dump_data", 64'(res_data), 64'(32'hC0DE0100 + 32'(k)));
      chk("dump_nodone", 64'(done), 64'd0);
      tick();
    end
    chk("dump_done",   64'(done),      64'd1);
    chk("dump_idle",   64'(busy),      64'd0);
    chk("idle_finish", 64'(wr_finish), 64'd0);
    tick();
    chk("done_pulse", 64'(done), 64'd0);

    // Address wrap with result backpressure
    res_rdy = 1'b0;
    pulse_start(15'd0, 9'h1FF, 10'd2);
    chk("w0cnt_finish", 64'(wr_finish), 64'd1);
    tick();
    work_state = 2'b11;
    tick();
    work_state = 2'b00;
    wait_res();
    chk("wrap_addr0", 64'(res_addr), 64'h1FF);
    chk("wrap_data0", 64'(res_data), 64'hC0DE01FF);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_vld",  64'(res_vld),  64'd1);
      chk("hold_addr", 64'(res_addr), 64'h1FF);
      chk("hold_data", 64'(res_data), 64'hC0DE01FF);
    end
    res_rdy = 1'b1;
    tick();
    wait_res();
    chk("wrap_addr1", 64'(res_addr), 64'h000);
    chk("wrap_data1", 64'(res_data), 64'hC0DE0000);
    tick();
    chk("wrap_done",   64'(done),   64'd1);
    chk("wrap_cycles", 64'(cycles), 64'd0);

    // Core error together with done: fault wins
    pulse_start(15'd0, 9'h000, 10'd1);
    tick();
    for (int i = 0; i < 5; i++) tick();
    err = 3'b010;
    work_state = 2'b11;
    tick();
    err = '0;
    work_state = 2'b00;
    chk("err_fault", 64'(fault), 64'd1);
    chk("err_busy",  64'(busy),  64'd1);
    chk("err_nodone", 64'(done), 64'd0);
    tick();
    chk("err_idle",   64'(busy),  64'd0);
    chk("err_done",   64'(done),  64'd0);
    chk("err_sticky", 64'(fault), 64'd1);

    // Timeout with no DONE
    pulse_start(15'd0, 9'h000, 10'd1);
    chk("to_cleared", 64'(fault), 64'd0);
    n = 0;
    while (fault == 2'b00 && n < 200) begin
      tick();
      n++;
    end
    chk("to_fault",  64'(fault),  64'd2);
    chk("to_cycles", 64'(cycles), 64'd50);
    tick();
    chk("to_idle", 64'(busy), 64'd0);
    chk("to_done", 64'(done), 64'd0);

    // Reset in the middle of a load, then a clean reload
    pulse_start(15'd1, 9'h000, 10'd0);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_busy",    64'(busy),      64'd0);
    chk("mrst_byterdy", 64'(byte_rdy),  64'd0);
    chk("mrst_wrvld",   64'(wr_vld),    64'd0);
    chk("mrst_wrdata",  wr_data,        64'd0);
    chk("mrst_finish",  64'(wr_finish), 64'd0);
    chk("mrst_fault",   64'(fault),     64'd0);
    pulse_start(15'd1, 9'h000, 10'd0);
    for (int i = 0; i < 8; i++) send_byte(8'h10 + 8'(i));
    chk("reload_vld",  64'(wr_vld),  64'd1);
    chk("reload_addr", 64'(wr_addr), 64'd0);
    chk("reload_data", wr_data,      64'h1716151413121110);
    tick();
    chk("reload_finish", 64'(wr_finish), 64'd1);
    tick();
    work_state = 2'b11;
    tick();
    work_state = 2'b00;
    tick();
    chk("cnt0_done", 64'(done), 64'd1);
    chk("cnt0_idle", 64'(busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
